// File: rtl/lin_block_codec_stream.sv
// Systematic linear block encoder / syndrome checker with valid/ready streaming,
// a 2-entry in-order output FIFO and saturating word/error counters.
module lin_block_codec_stream #(
  parameter int K = 6,
  parameter int N = 19,
  parameter logic [(N-K)*K-1:0] P_MATRIX = {6'h0E, 6'h36, 6'h1A, 6'h14, 6'h09, 6'h33, 6'h23,
                                            6'h14, 6'h3A, 6'h19, 6'h2C, 6'h30, 6'h33},
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [N-K-1:0]   out_syn,
  output logic             out_err,
  output logic             out_mode,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int M = N - K;

  logic [M-1:0] par;
  logic [M-1:0] syn;

  genvar gi;
  generate
    for (gi = 0; gi < M; gi++) begin : g_par
      assign par[gi] = ^(in_data[K-1:0] & P_MATRIX[gi*K +: K]);
      assign syn[gi] = par[gi] ^ in_data[K+gi];
    end
  endgenerate

  logic [N-1:0] new_data;
  logic [M-1:0] new_syn;
  logic         new_err;

  assign new_data = in_mode ? in_data : {par, in_data[K-1:0]};
  assign new_syn  = in_mode ? syn : '0;
  assign new_err  = in_mode & (|syn);

  logic [N-1:0]     data_q [2];
  logic [M-1:0]     syn_q  [2];
  logic             err_q  [2];
  logic             mode_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic push, pop;

  // in_ready depends only on the registered fill level, never on out_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_data = data_q[rd_ptr_q];
  assign out_syn  = syn_q[rd_ptr_q];
  assign out_err  = err_q[rd_ptr_q];
  assign out_mode = mode_q[rd_ptr_q];
  assign word_cnt = word_cnt_q;
  assign err_cnt  = err_cnt_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (!push && pop) begin
      count_d = count_q - 2'd1;
    end
  end

  // Clear wins over increment; both counters stick at all-ones.
  always_comb begin
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (cnt_clr) begin
      word_cnt_d = '0;
      err_cnt_d  = '0;
    end else if (push) begin
      if (word_cnt_q != '1) word_cnt_d = word_cnt_q + CNT_W'(1);
      if (new_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        syn_q[i]  <= '0;
        err_q[i]  <= 1'b0;
        mode_q[i] <= 1'b0;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= new_data;
        syn_q[wr_ptr_q]  <= new_syn;
        err_q[wr_ptr_q]  <= new_err;
        mode_q[wr_ptr_q] <= in_mode;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_lin_block_codec_stream.sv
// Bench for lin_block_codec_stream: vector table, directed FIFO/counter/reset
// sequences, then random traffic against a queue-based reference model.
module tb_lin_block_codec_stream;
  localparam int K = 6;
  localparam int N = 19;
  localparam int M = N - K;
  localparam int CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;
  localparam logic [M*K-1:0] P = {6'h0E, 6'h36, 6'h1A, 6'h14, 6'h09, 6'h33, 6'h23,
                                  6'h14, 6'h3A, 6'h19, 6'h2C, 6'h30, 6'h33};

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_mode;
  logic [N-1:0]     in_data;
  logic             out_valid, out_ready;
  logic [N-1:0]     out_data;
  logic [M-1:0]     out_syn;
  logic             out_err, out_mode;
  logic             cnt_clr;
  logic [CNT_W-1:0] word_cnt, err_cnt;

  lin_block_codec_stream #(.K(K), .N(N), .P_MATRIX(P), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_syn(out_syn),
    .out_err(out_err), .out_mode(out_mode),
    .cnt_clr(cnt_clr), .word_cnt(word_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int m_word   = 0;
  int m_err    = 0;

  typedef struct packed {
    logic         mode;
    logic [N-1:0] data;
    logic [M-1:0] syn;
    logic         err;
  } ent_t;

  typedef struct {
    logic         mode;
    logic [N-1:0] din;
    logic [N-1:0] exp_data;
    logic [M-1:0] exp_syn;
    logic         exp_err;
  } vec_t;

  vec_t vecs[9];
  ent_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Parity as the XOR of generator columns selected by the set data bits.
  function automatic logic [M-1:0] ref_parity(input logic [K-1:0] d);
    logic [M-1:0] p = '0;
    for (int i = 0; i < K; i++)
      if (d[i])
        for (int j = 0; j < M; j++) p[j] = p[j] ^ P[j*K + i];
    return p;
  endfunction

  function automatic ent_t ref_entry(input logic mode, input logic [N-1:0] din);
    ent_t e;
    logic [M-1:0] p = ref_parity(din[K-1:0]);
    e.mode = mode;
    if (!mode) begin
      e.data = {p, din[K-1:0]};
      e.syn  = '0;
      e.err  = 1'b0;
    end else begin
      e.data = din;
      e.syn  = p ^ din[N-1:K];
      e.err  = (e.syn != '0);
    end
    return e;
  endfunction

  task automatic model_count(input logic clr, input logic acc, input ent_t e);
    if (clr) begin
      m_word = 0;
      m_err  = 0;
    end else if (acc) begin
      if (m_word != CMAX) m_word++;
      if (e.err && m_err != CMAX) m_err++;
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, " word_cnt"}, 64'(word_cnt), 64'(m_word));
    chk({tag, " err_cnt"},  64'(err_cnt),  64'(m_err));
  endtask

  initial begin
    ent_t e;
    logic acc, pop;
    vecs[0] = '{1'b0, 19'h00001, 19'h07241, 13'h0000, 1'b0};
    vecs[1] = '{1'b0, 19'h0003F, 19'h5133F, 13'h0000, 1'b0};
    vecs[2] = '{1'b1, 19'h5133F, 19'h5133F, 13'h0000, 1'b0};
    vecs[3] = '{1'b1, 19'h07240, 19'h07240, 13'h01C9, 1'b1};
    vecs[4] = '{1'b0, 19'h7FFC1, 19'h07241, 13'h0000, 1'b0};
    vecs[5] = '{1'b1, 19'h07241, 19'h07241, 13'h0000, 1'b0};
    vecs[6] = '{1'b1, 19'h00000, 19'h00000, 13'h0000, 1'b0};
    vecs[7] = '{1'b1, 19'h5133E, 19'h5133E, 13'h01C9, 1'b1};
    vecs[8] = '{1'b0, 19'h00000, 19'h00000, 13'h0000, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_data", 64'(out_data), 64'd0);
    chk("reset out_syn", 64'(out_syn), 64'd0);
    chk("reset out_err", 64'(out_err), 64'd0);
    chk_counters("reset");
    rst_n = 1'b1;

    // Table vectors, one word at a time with out_ready high.
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_mode = vecs[i].mode; in_data = vecs[i].din;
      model_count(1'b0, 1'b1, ref_entry(vecs[i].mode, vecs[i].din));
      @(negedge clk);
      in_valid = 1'b0; in_data = N'($urandom); in_mode = 1'($urandom);
      $display("vec %0d mode=%0d in=%05h out=%05h syn=%04h err=%0b",
               i, vecs[i].mode, vecs[i].din, out_data, out_syn, out_err);
      chk("vec out_valid", 64'(out_valid), 64'd1);
      chk("vec out_data", 64'(out_data), 64'(vecs[i].exp_data));
      chk("vec out_syn", 64'(out_syn), 64'(vecs[i].exp_syn));
      chk("vec out_err", 64'(out_err), 64'(vecs[i].exp_err));
      chk("vec out_mode", 64'(out_mode), 64'(vecs[i].mode));
      chk_counters("vec");
    end
    @(negedge clk);
    chk("drained out_valid", 64'(out_valid), 64'd0);

    // Backpressure: fill both entries, third word waits for the first pop.
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 1'b0; in_data = 19'h00001;
    model_count(1'b0, 1'b1, ref_entry(1'b0, 19'h00001));
    @(negedge clk);
    chk("bp in_ready after 1", 64'(in_ready), 64'd1);
    in_mode = 1'b1; in_data = 19'h07240;
    model_count(1'b0, 1'b1, ref_entry(1'b1, 19'h07240));
    @(negedge clk);
    chk("bp in_ready after 2", 64'(in_ready), 64'd0);
    in_mode = 1'b0; in_data = 19'h0003F;
    @(negedge clk);
    chk("bp in_ready held", 64'(in_ready), 64'd0);
    chk("bp head stable", 64'(out_data), 64'h07241);
    chk("bp word_cnt held", 64'(word_cnt), 64'(m_word));
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp in_ready after pop", 64'(in_ready), 64'd1);
    chk("bp second word", 64'(out_data), 64'h07240);
    chk("bp second err", 64'(out_err), 64'd1);
    model_count(1'b0, 1'b1, ref_entry(1'b0, 19'h0003F));
    @(negedge clk);
    in_valid = 1'b0;
    $display("bp third word out=%05h", out_data);
    chk("bp third word", 64'(out_data), 64'h5133F);
    chk("bp third valid", 64'(out_valid), 64'd1);
    chk_counters("bp");
    @(negedge clk);
    chk("bp drained", 64'(out_valid), 64'd0);

    // Counter saturation, then clear colliding with an accept.
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    model_count(1'b1, 1'b0, '0);
    chk_counters("clr");
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_mode = 1'b1; in_data = 19'h07240;
      model_count(1'b0, 1'b1, ref_entry(1'b1, 19'h07240));
      @(negedge clk);
    end
    $display("sat word_cnt=%0h err_cnt=%0h", word_cnt, err_cnt);
    chk("sat word_cnt", 64'(word_cnt), 64'hF);
    chk("sat err_cnt", 64'(err_cnt), 64'hF);
    cnt_clr = 1'b1;
    model_count(1'b1, 1'b1, ref_entry(1'b1, 19'h07240));
    @(negedge clk);
    cnt_clr = 1'b0; in_valid = 1'b0;
    chk("clr+acc word_cnt", 64'(word_cnt), 64'd0);
    chk("clr+acc err_cnt", 64'(err_cnt), 64'd0);
    @(negedge clk);
    @(negedge clk);

    // Asynchronous reset with a full FIFO.
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 1'b0; in_data = 19'h0003F;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre-reset full", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset out_valid=%0b in_ready=%0b word_cnt=%0h", out_valid, in_ready, word_cnt);
    chk("arst out_valid", 64'(out_valid), 64'd0);
    chk("arst in_ready", 64'(in_ready), 64'd1);
    chk("arst word_cnt", 64'(word_cnt), 64'd0);
    chk("arst err_cnt", 64'(err_cnt), 64'd0);
    chk("arst out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_word = 0; m_err = 0;
    exp_q.delete();

    // Random traffic against the queue model.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      chk("rnd in_ready", 64'(in_ready), 64'(exp_q.size() != 2));
      chk("rnd out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("rnd out_data", 64'(out_data), 64'(exp_q[0].data));
        chk("rnd out_syn", 64'(out_syn), 64'(exp_q[0].syn));
        chk("rnd out_err", 64'(out_err), 64'(exp_q[0].err));
        chk("rnd out_mode", 64'(out_mode), 64'(exp_q[0].mode));
      end
      chk_counters("rnd");

      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cnt_clr   = ($urandom_range(0, 29) == 0);
      in_mode   = 1'($urandom);
      in_data   = N'($urandom);
      if (in_mode && $urandom_range(0, 1) == 1) begin
        e = ref_entry(1'b0, in_data);
        in_data = e.data;
        if ($urandom_range(0, 1) == 1) in_data[$urandom_range(0, N-1)] ^= 1'b1;
      end

      acc = in_valid && (exp_q.size() != 2);
      pop = out_ready && (exp_q.size() != 0);
      e = ref_entry(in_mode, in_data);
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(e);
      model_count(cnt_clr, acc, e);
    end
    @(negedge clk);
    chk("final out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    chk_counters("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
